// File: rtl/aes_iter_core.sv
// Iterative AES encryptor: on-chip key expansion (one word per cycle) and one full round per cycle.
// Key length is set by NK (4/6/8 words); blocks use the byte order of FIPS-197, byte 0 in the MSBs.
module aes_iter_core #(
   parameter int NK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [32*NK-1:0]  key_in,
   input  logic              key_load,
   output logic              key_ready,
   input  logic [127:0]      in,
   input  logic              valid_in,
   output logic              ready_in,
   output logic [127:0]      out,
   output logic              valid_out,
   input  logic              ready_out
);

   // state  | meaning
   // IDLE   | waiting for key_load or a plaintext block
   // KEYEXP | expanding the key, one word per cycle
   // ROUND  | applying rounds 1..NR, one per cycle
   // DONE   | ciphertext held on out until downstream takes it

   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);

   if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("aes_iter_core: NK must be 4, 6 or 8");
   end

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX[a];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

   state_t        state, state_nxt;
   logic [31:0]   w [NW];
   logic [5:0]    kcnt, widx;
   logic [2:0]    kmod;
   logic [7:0]    rcon;
   logic [3:0]    rnd;
   logic [127:0]  st;
   logic          key_go, accept, key_last, last_round;
   logic [31:0]   w_prev, w_back, sub_w, temp, w_new;
   logic [127:0]  rk, rk0, sb_v, sr_v, mc_v, round_out;

   // ---------------- key schedule ----------------
   assign widx     = 6'(NK) + kcnt;
   assign w_prev   = w[widx - 6'd1];
   assign w_back   = w[widx - 6'(NK)];
   assign key_last = (kcnt == 6'(NW - NK - 1));

   for (genvar b = 0; b < 4; b++) begin : g_ksbox
      assign sub_w[31-8*b -: 8] = sbox(w_prev[31-8*b -: 8]);
   end

   // SubWord and RotWord commute, so the rotation is applied after the lookup.
   always_comb begin
      temp = w_prev;
      if (kmod == 3'd0)
         temp = {sub_w[23:0], sub_w[31:24]} ^ {rcon, 24'h0};
      else if (NK == 8 && kmod == 3'd4)
         temp = sub_w;
      w_new = w_back ^ temp;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (key_go) begin
            for (int j = 0; j < NK; j++)
               w[j] <= key_in[32*(NK-1-j) +: 32];
         end else if (state == KEYEXP) begin
            w[widx] <= w_new;
         end
      end
   end

   // ---------------- round datapath ----------------
   assign rk0 = {w[0], w[1], w[2], w[3]};
   assign rk  = {w[{rnd, 2'd0}], w[{rnd, 2'd1}], w[{rnd, 2'd2}], w[{rnd, 2'd3}]};
   assign last_round = (rnd == 4'(NR));

   for (genvar k = 0; k < 16; k++) begin : g_sbox
      assign sb_v[127-8*k -: 8] = sbox(st[127-8*k -: 8]);
   end

   // Byte 4c+r is row r of column c; row r rotates left by r columns.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr_v[127-8*(4*c+r) -: 8] = sb_v[127-8*(4*((c+r)%4)+r) -: 8];
      end
      assign mc_v[127-32*c -: 32] = mix_col(sr_v[127-32*c -: 32]);
   end

   assign round_out = (last_round ? sr_v : mc_v) ^ rk;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (key_load) state_nxt = KEYEXP;
                  else if (accept) state_nxt = ROUND;
         KEYEXP:  if (!key_load && key_last) state_nxt = IDLE;
         ROUND:   if (last_round) state_nxt = DONE;
         DONE:    if (accept) state_nxt = ROUND;
                  else if (ready_out) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready_in = key_ready && !key_load &&
                 (state == IDLE || (state == DONE && ready_out));
      accept   = valid_in && ready_in;
      key_go   = key_load && (state == IDLE || state == KEYEXP);
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         key_ready <= 1'b0;
         kcnt      <= '0;
         kmod      <= '0;
         rcon      <= 8'h01;
         rnd       <= '0;
         st        <= '0;
         out       <= '0;
         valid_out <= 1'b0;
      end else begin
         if (key_go) begin
            key_ready <= 1'b0;
            kcnt      <= '0;
            kmod      <= '0;
            rcon      <= 8'h01;
         end else if (state == KEYEXP) begin
            kcnt <= kcnt + 6'd1;
            kmod <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
            if (kmod == 3'd0) rcon <= xt(rcon);
            if (key_last) key_ready <= 1'b1;
         end

         if (accept) begin
            st  <= in ^ rk0;
            rnd <= 4'd1;
         end else if (state == ROUND) begin
            st <= round_out;
            if (last_round) begin
               out       <= round_out;
               valid_out <= 1'b1;
            end else begin
               rnd <= rnd + 4'd1;
            end
         end

         if (state == DONE && ready_out) valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 vectors for all three key sizes on parallel instances,
// plus backpressure, back-to-back, reset abort, key_load arbitration and SP800-38A streaming on NK=4.
module tb_aes_iter_core;

   logic          clk = 1'b0;
   logic          rst, key_load, valid_in, ready_out;
   logic [127:0]  in;
   logic [127:0]  key_in4;
   logic [191:0]  key_in6;
   logic [255:0]  key_in8;
   logic          key_ready4, key_ready6, key_ready8;
   logic          ready_in4, ready_in6, ready_in8;
   logic          valid_out4, valid_out6, valid_out8;
   logic [127:0]  out4, out6, out8;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FIPS_CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] FIPS_CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] SP_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic [127:0] spt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                             128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
   logic [127:0] sct [4] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
                             128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4};

   always #5 clk = ~clk;

   aes_iter_core #(.NK(4)) dut4 (.clk(clk), .rst(rst), .key_in(key_in4), .key_load(key_load),
      .key_ready(key_ready4), .in(in), .valid_in(valid_in), .ready_in(ready_in4),
      .out(out4), .valid_out(valid_out4), .ready_out(ready_out));
   aes_iter_core #(.NK(6)) dut6 (.clk(clk), .rst(rst), .key_in(key_in6), .key_load(key_load),
      .key_ready(key_ready6), .in(in), .valid_in(valid_in), .ready_in(ready_in6),
      .out(out6), .valid_out(valid_out6), .ready_out(ready_out));
   aes_iter_core #(.NK(8)) dut8 (.clk(clk), .rst(rst), .key_in(key_in8), .key_load(key_load),
      .key_ready(key_ready8), .in(in), .valid_in(valid_in), .ready_in(ready_in8),
      .out(out8), .valid_out(valid_out8), .ready_out(ready_out));

   task automatic chk_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs == exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles after the key_load edge at which each instance first shows key_ready.
   task automatic wait_keys(output int c4, output int c6, output int c8, output logic vo_seen);
      c4 = 0; c6 = 0; c8 = 0; vo_seen = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (key_ready4 && c4 == 0) c4 = c;
         if (key_ready6 && c6 == 0) c6 = c;
         if (key_ready8 && c8 == 0) c8 = c;
         if (valid_out4) vo_seen = 1'b1;
      end
   endtask

   initial begin
      int   k4, k6, k8, v4, v6, v8, ai, n_out;
      int   acc_c [4];
      int   out_c [4];
      logic seen, acc;
      logic [127:0] cap;

      rst = 1'b1; key_load = 1'b0; valid_in = 1'b0; ready_out = 1'b0; in = '0;
      key_in4 = 128'h000102030405060708090a0b0c0d0e0f;
      key_in6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
      key_in8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      repeat (3) tick();
      chk_b("rst_key_ready", key_ready4, 1'b0);
      chk_b("rst_valid_out", valid_out4, 1'b0);
      chk_v("rst_out", out4, '0);

      // No key yet: block must be refused.
      rst = 1'b0; valid_in = 1'b1; in = FIPS_PT; #1;
      chk_b("nokey_ready_in", ready_in4, 1'b0);
      tick();
      chk_b("nokey_valid_out", valid_out4, 1'b0);
      valid_in = 1'b0;

      // Key expansion latency for all three key sizes.
      key_load = 1'b1; tick(); key_load = 1'b0;
      chk_b("keyexp_not_ready", key_ready4, 1'b0);
      wait_keys(k4, k6, k8, seen);
      chk_i("keyexp_lat4", k4, 40);
      chk_i("keyexp_lat6", k6, 46);
      chk_i("keyexp_lat8", k8, 52);

      // FIPS-197 encryption on all three, downstream stalled.
      in = FIPS_PT; valid_in = 1'b1; #1;
      chk_b("ready_in4", ready_in4, 1'b1);
      chk_b("ready_in6", ready_in6, 1'b1);
      chk_b("ready_in8", ready_in8, 1'b1);
      tick(); valid_in = 1'b0;
      v4 = 0; v6 = 0; v8 = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (valid_out4 && v4 == 0) v4 = c;
         if (valid_out6 && v6 == 0) v6 = c;
         if (valid_out8 && v8 == 0) v8 = c;
      end
      chk_i("enc_lat4", v4, 10);
      chk_i("enc_lat6", v6, 12);
      chk_i("enc_lat8", v8, 14);
      chk_v("enc_ct4", out4, FIPS_CT4);
      chk_v("enc_ct6", out6, FIPS_CT6);
      chk_v("enc_ct8", out8, FIPS_CT8);

      // Backpressure: output held, no new block taken even with valid_in up.
      valid_in = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk_v("hold_out", out4, FIPS_CT4);
         chk_b("hold_valid_out", valid_out4, 1'b1);
         chk_b("hold_ready_in", ready_in4, 1'b0);
      end

      // Release with valid_in high: transfer and accept on the same edge.
      ready_out = 1'b1; #1;
      chk_b("b2b_ready_in", ready_in4, 1'b1);
      tick(); valid_in = 1'b0;
      chk_b("b2b_valid_out_drop", valid_out4, 1'b0);
      key_in4 = '1;
      v4 = 0; cap = '0;
      for (int c = 1; c <= 20; c++) begin
         key_load = (c == 4);
         tick();
         if (valid_out4 && v4 == 0) begin
            v4 = c;
            cap = out4;
         end
      end
      key_load = 1'b0;
      chk_i("b2b_lat", v4, 10);
      chk_v("b2b_ct_keyload_ignored", cap, FIPS_CT4);
      chk_b("b2b_key_ready_kept", key_ready4, 1'b1);
      chk_b("b2b_valid_out_single", valid_out4, 1'b0);

      // Reset while round 5 is pending: block discarded, key lost.
      in = FIPS_PT; valid_in = 1'b1;
      tick(); valid_in = 1'b0;
      repeat (4) tick();
      rst = 1'b1; key_load = 1'b1; valid_in = 1'b1;
      tick();
      rst = 1'b0; key_load = 1'b0;
      chk_b("abort_key_ready", key_ready4, 1'b0);
      chk_b("abort_valid_out", valid_out4, 1'b0);
      chk_v("abort_out", out4, '0);
      chk_b("abort_ready_in", ready_in4, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (valid_out4 || key_ready4) seen = 1'b1;
      end
      chk_b("abort_quiet", seen, 1'b0);
      valid_in = 1'b0;

      // Re-key with the SP800-38A key.
      key_in4 = SP_KEY; key_load = 1'b1; tick(); key_load = 1'b0;
      wait_keys(k4, k6, k8, seen);
      chk_i("rekey_lat4", k4, 40);

      // key_load beats valid_in in IDLE.
      in = spt[0]; valid_in = 1'b1; key_load = 1'b1; #1;
      chk_b("klvi_ready_in", ready_in4, 1'b0);
      tick(); key_load = 1'b0; valid_in = 1'b0;
      chk_b("klvi_key_ready", key_ready4, 1'b0);
      wait_keys(k4, k6, k8, seen);
      chk_i("klvi_lat4", k4, 40);
      chk_b("klvi_no_output", seen, 1'b0);

      // Streaming four blocks with valid_in and ready_out held high.
      ai = 0; n_out = 0;
      for (int k = 0; k < 4; k++) begin
         acc_c[k] = 0;
         out_c[k] = 0;
      end
      in = spt[0]; valid_in = 1'b1; ready_out = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         acc = valid_in && ready_in4;
         tick();
         if (acc) begin
            if (ai < 4) acc_c[ai] = c;
            ai++;
            if (ai < 4) in = spt[ai];
            else valid_in = 1'b0;
         end
         if (valid_out4) begin
            if (n_out < 4) begin
               chk_v("stream_ct", out4, sct[n_out]);
               out_c[n_out] = c;
            end
            n_out++;
         end
      end
      chk_i("stream_accepts", ai, 4);
      chk_i("stream_outputs", n_out, 4);
      chk_i("stream_first_lat", out_c[0] - acc_c[0], 10);
      for (int k = 1; k < 4; k++) begin
         chk_i("stream_acc_gap", acc_c[k] - acc_c[k-1], 11);
         chk_i("stream_out_gap", out_c[k] - out_c[k-1], 11);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
